// File: rtl/sched_pkg.sv
// Shared types for the step scheduler: FSM states, program entry layout and
// the per-speed period table built at elaboration time.
package sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  typedef struct packed {
    logic [3:0] speed;
    logic       dir;
    logic [3:0] count;
  } entry_t;

  typedef logic [15:0][31:0] ptab_t;

  function automatic int unsigned period_of(int unsigned one_sec, int unsigned speed);
    return (speed == 0) ? 0 : one_sec / speed;
  endfunction

  // Constant table indexed by speed; speed 0 maps to 0 and is never timed.
  function automatic ptab_t period_tab(int unsigned one_sec);
    ptab_t t;
    t = '0;
    for (int s = 1; s < 16; s++) t[s] = period_of(one_sec, s);
    return t;
  endfunction

endpackage

// File: rtl/trig_debounce.sv
// Manual button path: 2-flop synchronizer, stability counter and a registered
// one-cycle pulse on each accepted rising edge of the debounced level.
module trig_debounce #(
  parameter int unsigned DEBOUNCE = 240000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic trig_i,
  output logic rise_o
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          s1_q, s2_q, lvl_q, lvl_dly_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q <= trig_i;
      s2_q <= s1_q;
      // Level flips on the DEBOUNCE-th consecutive sample that differs from it.
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      lvl_dly_q <= lvl_q;
      rise_q    <= lvl_q & ~lvl_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/step_scheduler.sv
// Program sequencer for the light-pattern machine: runs a small table of
// {speed, dir, count} segments, or passes debounced manual steps in IDLE.
module step_scheduler
  import sched_pkg::*;
#(
  parameter  int unsigned ONE_SECOND = 12000000,
  parameter  int unsigned DEBOUNCE   = 240000,
  parameter  int unsigned ENTRIES    = 4,
  localparam int          IW         = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic          clk,
  input  logic          CR,
  input  logic          mode,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          loop,
  input  logic          trigger,
  input  logic          man_dir,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [3:0]    cfg_speed,
  input  logic          cfg_dir,
  input  logic [3:0]    cfg_count,
  output logic          step,
  output logic          dir,
  output logic          busy,
  output logic          paused,
  output logic [IW-1:0] idx,
  output logic          done
);
  localparam int    TW   = (ONE_SECOND > 1) ? $clog2(ONE_SECOND) : 1;
  localparam ptab_t PTAB = period_tab(ONE_SECOND);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] timer_q, last_q;
  logic [3:0]    rem_q;
  logic          stepped_q, step_q, done_q, dir_q;
  entry_t        tbl_q [ENTRIES];

  logic          man_rise, wr_ok, start_ok, at_last;
  entry_t        cfg_e, ld_e;
  logic [IW-1:0] ld_idx;
  logic [TW-1:0] ld_last;
  logic [3:0]    ld_rem;

  trig_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk    (clk),
    .rst_i  (CR),
    .trig_i (trigger),
    .rise_o (man_rise)
  );

  always_comb begin
    cfg_e    = {cfg_speed, cfg_dir, cfg_count};
    wr_ok    = cfg_we && (state_q == S_IDLE);
    start_ok = (state_q == S_IDLE) && start && !mode && !abort && !pause;
    at_last  = (idx_q == IW'(ENTRIES - 1));
    ld_idx   = (start_ok || at_last) ? '0 : idx_q + 1'b1;
    ld_e     = tbl_q[ld_idx];
    // A write landing with an accepted start is forwarded to the first load.
    if (wr_ok && (cfg_addr == ld_idx)) ld_e = cfg_e;
    ld_last  = TW'(PTAB[ld_e.speed] - 1);
    ld_rem   = (ld_e.speed == 4'd0) ? 4'd0 : ld_e.count;
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i] <= '0;
    end else if (wr_ok) begin
      tbl_q[cfg_addr] <= cfg_e;
    end
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      last_q    <= '0;
      rem_q     <= '0;
      stepped_q <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q   <= S_RUN;
            idx_q     <= ld_idx;
            timer_q   <= '0;
            last_q    <= ld_last;
            rem_q     <= ld_rem;
            dir_q     <= ld_e.dir;
            stepped_q <= 1'b0;
          end else begin
            dir_q <= man_dir;
            if (mode && man_rise) step_q <= 1'b1;
          end
        end
        default: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (state_q == S_RUN && pause) begin
            state_q <= S_PAUSE;
          end else if (state_q == S_RUN || pause) begin
            // The resume edge also counts as a running cycle.
            state_q <= S_RUN;
            if (rem_q == 4'd0) begin
              if (!at_last || (loop && stepped_q)) begin
                idx_q   <= ld_idx;
                timer_q <= '0;
                last_q  <= ld_last;
                rem_q   <= ld_rem;
                dir_q   <= ld_e.dir;
                if (at_last) stepped_q <= 1'b0;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end else if (timer_q == last_q) begin
              step_q    <= 1'b1;
              timer_q   <= '0;
              rem_q     <= rem_q - 1'b1;
              stepped_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign step   = step_q;
  assign done   = done_q;
  assign dir    = dir_q;
  assign idx    = idx_q;
  assign busy   = (state_q != S_IDLE);
  assign paused = (state_q == S_PAUSE);

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench: stimulus queues expected step/done pulses, a negedge
// monitor pops and checks kind, cycle and dir for every pulse the DUT emits.
module tb_step_scheduler;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          CR, mode, start, pause, abort, loop, trigger, man_dir;
  logic          cfg_we, cfg_dir;
  logic [IW-1:0] cfg_addr;
  logic [3:0]    cfg_speed, cfg_count;
  logic          step, dir, busy, paused, done;
  logic [IW-1:0] idx;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t;

  typedef struct {
    bit is_done;
    int at;
    bit d;
  } ev_t;
  ev_t expq[$];
  ev_t mev;

  step_scheduler #(.ONE_SECOND(60), .DEBOUNCE(4), .ENTRIES(4)) dut (
    .clk(clk), .CR(CR), .mode(mode), .start(start), .pause(pause),
    .abort(abort), .loop(loop), .trigger(trigger), .man_dir(man_dir),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_speed(cfg_speed),
    .cfg_dir(cfg_dir), .cfg_count(cfg_count), .step(step), .dir(dir),
    .busy(busy), .paused(paused), .idx(idx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step === 1'b1 || done === 1'b1) begin
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got step=%0b done=%0b at cycle %0d, required no pulse",
                 step, done, cyc);
      end else begin
        mev = expq.pop_front();
        if (mev.is_done != done || mev.is_done == step || mev.at != cyc ||
            (!mev.is_done && mev.d != dir)) begin
          n_fail++;
          $display("FAIL pulse_check: got step=%0b done=%0b dir=%0b at cycle %0d, required %s dir=%0b at cycle %0d",
                   step, done, dir, cyc, mev.is_done ? "done" : "step", mev.d, mev.at);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(bit is_done, int at, bit d);
    ev_t e;
    e.is_done = is_done;
    e.at      = at;
    e.d       = d;
    expq.push_back(e);
  endtask

  task automatic wr(int a, int sp, int d, int c);
    cfg_we    = 1'b1;
    cfg_addr  = a[IW-1:0];
    cfg_speed = sp[3:0];
    cfg_dir   = d[0];
    cfg_count = c[3:0];
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic go_start();
    start = 1'b1;
    t = cyc + 1;
  endtask

  task automatic drain(string nm);
    chk(nm, expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    CR = 1'b1; mode = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    loop = 1'b0; trigger = 1'b0; man_dir = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_speed = '0; cfg_dir = 1'b0; cfg_count = '0;
    tick(3);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paused", paused, 0);
    chk("rst_idx", idx, 0);
    chk("rst_done", done, 0);
    CR = 1'b0;
    tick(2);

    // Program {3,1,2},{6,0,1},{0,x,x},{0,x,x}
    wr(0, 3, 1, 2);
    wr(1, 6, 0, 1);
    tick(2);

    // One pass, no loop
    go_start();
    push(0, t + 20, 1); push(0, t + 40, 1); push(0, t + 51, 0); push(1, t + 54, 0);
    tick(1); start = 1'b0;
    chk("run_busy", busy, 1);
    wait_until(t + 40); chk("run_dir_before", dir, 1);
    wait_until(t + 41); chk("run_dir_after", dir, 0);
    wait_until(t + 54); chk("run_idle_after_done", busy, 0);
    wait_until(t + 60); drain("run_queue");

    // Loop wrap, a dropped busy write, abort on a due step
    loop = 1'b1;
    go_start();
    push(0, t + 20, 1); push(0, t + 40, 1); push(0, t + 51, 0); push(0, t + 74, 1);
    tick(1); start = 1'b0;
    wait_until(t + 53); chk("loop_idx_last", idx, 3);
    wait_until(t + 54); chk("loop_idx_wrap", idx, 0);
    chk("loop_busy_wrap", busy, 1);
    wait_until(t + 60); wr(2, 15, 1, 15);
    wait_until(t + 93); abort = 1'b1;
    tick(1); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_step", step, 0);
    tick(10); drain("loop_abort_queue");
    loop = 1'b0;

    // Pause for 30 cycles from t+10
    go_start();
    push(0, t + 50, 1); push(0, t + 70, 1); push(0, t + 81, 0); push(1, t + 84, 0);
    tick(1); start = 1'b0;
    wait_until(t + 9); pause = 1'b1;
    tick(1); pause = 1'b0;
    chk("pause_paused", paused, 1);
    chk("pause_busy", busy, 1);
    wait_until(t + 39); pause = 1'b1;
    tick(1); pause = 1'b0;
    chk("resume_paused", paused, 0);
    wait_until(t + 90); chk("pause_idle", busy, 0);
    drain("pause_queue");

    // All-zero pass with loop; entry 0 zeroed by a write in the start cycle
    wr(1, 0, 0, 0);
    loop = 1'b1;
    go_start();
    cfg_we = 1'b1; cfg_addr = '0; cfg_speed = 4'd0; cfg_dir = 1'b0; cfg_count = 4'd0;
    push(1, t + 4, 0);
    tick(1); start = 1'b0; cfg_we = 1'b0;
    wait_until(t + 3); chk("zero_idx", idx, 3);
    chk("zero_busy", busy, 1);
    wait_until(t + 4); chk("zero_idle", busy, 0);
    tick(6); drain("zero_queue");
    loop = 1'b0;

    // Manual mode: glitch, then a held press
    mode = 1'b1; man_dir = 1'b1;
    tick(2); chk("man_dir", dir, 1);
    trigger = 1'b1;
    tick(3); trigger = 1'b0;
    tick(15);
    trigger = 1'b1;
    push(0, cyc + 1 + 7, 1);
    tick(20); trigger = 1'b0;
    tick(15); drain("manual_queue");

    // Press while busy is ignored
    wr(0, 1, 0, 1);
    mode = 1'b0;
    go_start();
    tick(1); start = 1'b0;
    mode = 1'b1;
    trigger = 1'b1;
    tick(12); trigger = 1'b0;
    wait_until(t + 30); abort = 1'b1;
    tick(1); abort = 1'b0;
    tick(15);
    chk("busy_press_idle", busy, 0);
    drain("busy_press_queue");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
